// File: rtl/slice_adder_pkg.sv
// Shared types and sizing helpers for the sequential slice adder.
// The slice width is fixed by the 8-bit hybrid_adder datapath.
package slice_adder_pkg;

   localparam int SLICE = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int nslice(input int width, input int slice);
      return width / slice;
   endfunction

   // Index needs at least one bit even when only a single slice exists.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slice_adder_seq_hybrid_adder.sv
// 8-bit hybrid adder: rippled low nibble, carry-selected high nibble.
// Shared slice datapath for the sequential wide adder.
module hybrid_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cy_in,
   output logic [7:0] sum,
   output logic       cy_out
);

   logic [4:0] c;
   logic [4:0] hi0;
   logic [4:0] hi1;

   assign c[0] = cy_in;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ripple
         assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   // Both high-nibble candidates are formed in parallel with the ripple.
   assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
   assign hi1 = hi0 + 5'd1;

   assign sum[7:4] = c[4] ? hi1[3:0] : hi0[3:0];
   assign cy_out   = c[4] ? hi1[4]   : hi0[4];

endmodule

// File: rtl/slice_adder_seq.sv
// WIDTH-bit add/subtract built from one 8-bit slice reused over WIDTH/8
// cycles, with the inter-slice carry held in a register.
import slice_adder_pkg::*;

module slice_adder_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = slice_adder_pkg::SLICE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cy_out,
   output logic             ovf
);

   localparam int NSLICE = nslice(WIDTH, SLICE);
   localparam int IDX_W  = idx_width(NSLICE);
   localparam int MSB    = WIDTH - 1;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   idx_reg;
   logic               carry_reg;
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic [WIDTH-1:0]   result_reg;
   logic               cy_out_reg;
   logic               ovf_reg;

   logic [SLICE-1:0]   slice_a;
   logic [SLICE-1:0]   slice_b;
   logic [SLICE-1:0]   slice_sum;
   logic               slice_cy;
   logic               last_slice;

   assign slice_a    = a_reg[int'(idx_reg)*SLICE +: SLICE];
   assign slice_b    = b_reg[int'(idx_reg)*SLICE +: SLICE];
   assign last_slice = (idx_reg == IDX_W'(NSLICE - 1));

   hybrid_adder u_slice (
      .a      (slice_a),
      .b      (slice_b),
      .cy_in  (carry_reg),
      .sum    (slice_sum),
      .cy_out (slice_cy)
   );

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: if (start) state_next = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (last_slice) state_next = S_DONE;
         end
         S_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1: B is stored inverted and the carry seeded.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg      <= '0;
         b_reg      <= '0;
         carry_reg  <= 1'b0;
         idx_reg    <= '0;
         result_reg <= '0;
         cy_out_reg <= 1'b0;
         ovf_reg    <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: if (start) begin
               a_reg      <= op_a;
               b_reg      <= sub ? ~op_b : op_b;
               carry_reg  <= sub;
               idx_reg    <= '0;
               result_reg <= '0;
               cy_out_reg <= 1'b0;
               ovf_reg    <= 1'b0;
            end
            S_RUN: begin
               result_reg[int'(idx_reg)*SLICE +: SLICE] <= slice_sum;
               carry_reg <= slice_cy;
               idx_reg   <= idx_reg + 1'b1;
               if (last_slice) begin
                  cy_out_reg <= slice_cy;
                  ovf_reg    <= (a_reg[MSB] == b_reg[MSB]) &&
                                (slice_sum[SLICE-1] != a_reg[MSB]);
               end
            end
            default: ;
         endcase
      end
   end

   assign result = result_reg;
   assign cy_out = cy_out_reg;
   assign ovf    = ovf_reg;

endmodule
